// File: rtl/seg7_scan_if.sv
// Bus bundle for the multiplexed 7-segment scan controller.
// The master drives display data and controls; the slave drives segment/anode outputs.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [8*NUM_DIGITS-1:0] i_data;
    logic                    load;
    logic                    disp_mode;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_suppress;
    logic [3:0]              brightness;
    logic [7:0]              disp_seg_o;
    logic [NUM_DIGITS-1:0]   disp_an_o;
    logic                    frame_done;

    modport master (
        output i_data, load, disp_mode, dp_mask, blank_mask, blink_mask,
               lz_suppress, brightness,
        input  disp_seg_o, disp_an_o, frame_done
    );

    modport slave (
        input  i_data, load, disp_mode, dp_mask, blank_mask, blink_mask,
               lz_suppress, brightness,
        output disp_seg_o, disp_an_o, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment display scanner with tear-free double buffering,
// hex/raw modes, leading-zero suppression, blink and 16-step PWM brightness.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV_W  = 15,
    parameter int BLINK_DIV_W = 5
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);
    localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SCAN_DIV_W-1:0]   cnt;
    logic [AW-1:0]           addr;
    logic [BLINK_DIV_W-1:0]  blink_cnt;
    logic [8*NUM_DIGITS-1:0] staging;
    logic [8*NUM_DIGITS-1:0] active;
    logic                    tick;
    logic                    last_slot;
    logic                    wrap;

    logic [7:0]              cur_byte;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    upper_zero;
    logic                    lz_dark;
    logic                    pwm_off;
    logic                    dark;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    assign tick      = &cnt;
    assign last_slot = (addr == AW'(NUM_DIGITS - 1));
    assign wrap      = tick & last_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            addr           <= '0;
            blink_cnt      <= '0;
            staging        <= '0;
            active         <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            cnt            <= cnt + 1'b1;
            bus.frame_done <= wrap;
            if (tick) begin
                addr <= last_slot ? '0 : addr + 1'b1;
            end
            if (bus.frame_done) begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (bus.load) begin
                staging <= bus.i_data;
            end
            // A load landing on the wrap tick bypasses staging so it is not lost a frame.
            if (wrap) begin
                active <= bus.load ? bus.i_data : staging;
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        cur_nib  = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (addr == AW'(i)) begin
                cur_byte = active[8*i +: 8];
                cur_nib  = active[4*i +: 4];
            end
        end
    end

    // Scan from the top digit down: a digit is a leading zero while everything above it is zero too.
    always_comb begin
        upper_zero = 1'b1;
        lz_vec     = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            upper_zero = upper_zero & (active[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
            lz_vec[NUM_DIGITS-1-j] = upper_zero;
        end
        lz_vec[0] = 1'b0;
    end

    always_comb begin
        lz_dark = ~bus.disp_mode & bus.lz_suppress & lz_vec[addr];
        pwm_off = cnt[SCAN_DIV_W-1 -: 4] > bus.brightness;
        dark    = bus.blank_mask[addr] | lz_dark | pwm_off
                | (bus.blink_mask[addr] & blink_cnt[BLINK_DIV_W-1]);

        seg_next = 8'hFF;
        an_next  = '1;
        if (!dark) begin
            if (bus.disp_mode) begin
                seg_next = cur_byte;
            end else begin
                seg_next = hex7(cur_nib) & ~{bus.dp_mask[addr], 7'b0};
            end
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                an_next[i] = (addr != AW'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.disp_seg_o <= 8'hFF;
            bus.disp_an_o  <= '1;
        end else begin
            bus.disp_seg_o <= seg_next;
            bus.disp_an_o  <= an_next;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: 8-digit and 5-digit scanners share one stimulus stream and are
// checked every cycle against a cycle-count based reference model.
module tb_seg7_scan_ctrl;
    localparam int SDW = 4;
    localparam int BDW = 2;
    localparam int SLOT = 1 << SDW;

    logic clk;
    logic rst;

    logic [63:0] data;
    logic        load;
    logic        mode;
    logic [7:0]  dp_v;
    logic [7:0]  blank_v;
    logic [7:0]  blink_v;
    logic        lzs;
    logic [3:0]  bright;

    int unsigned compared;
    int unsigned mismatched;

    // Reference model state: cycles since reset release plus the two data buffers per DUT.
    int unsigned k;
    logic [63:0] act8, stg8, act5, stg5;

    logic [7:0] hexlut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_if #(.NUM_DIGITS(8)) bus8 ();
    seg7_scan_if #(.NUM_DIGITS(5)) bus5 ();

    assign bus8.i_data      = data;
    assign bus8.load        = load;
    assign bus8.disp_mode   = mode;
    assign bus8.dp_mask     = dp_v;
    assign bus8.blank_mask  = blank_v;
    assign bus8.blink_mask  = blink_v;
    assign bus8.lz_suppress = lzs;
    assign bus8.brightness  = bright;

    assign bus5.i_data      = data[39:0];
    assign bus5.load        = load;
    assign bus5.disp_mode   = mode;
    assign bus5.dp_mask     = dp_v[4:0];
    assign bus5.blank_mask  = blank_v[4:0];
    assign bus5.blink_mask  = blink_v[4:0];
    assign bus5.lz_suppress = lzs;
    assign bus5.brightness  = bright;

    seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV_W(SDW), .BLINK_DIV_W(BDW)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV_W(SDW), .BLINK_DIV_W(BDW)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output expected one cycle after a state that is kk cycles past reset release.
    function automatic logic [16:0] model_out(int unsigned n, int unsigned kk, logic [63:0] act);
        int unsigned cnt, addr, frames;
        logic        blink_off, lz, dark, fd;
        logic [63:0] upper;
        logic [7:0]  seg, an, full;
        cnt       = kk % SLOT;
        addr      = (kk / SLOT) % n;
        frames    = (kk == 0) ? 0 : (kk - 1) / (SLOT * n);
        blink_off = ((frames % (1 << BDW)) >= (1 << (BDW - 1)));
        upper     = (act >> (4 * addr)) & ((64'd1 << (4 * (n - addr))) - 64'd1);
        lz        = !mode && lzs && (addr != 0) && (upper == 64'd0);
        dark      = blank_v[addr] || lz || (blink_v[addr] && blink_off) || (cnt > 32'(bright));
        if (dark) begin
            seg = 8'hFF;
        end else if (mode) begin
            seg = act[8*addr +: 8];
        end else begin
            seg = hexlut[act[4*addr +: 4]];
            if (dp_v[addr]) seg[7] = 1'b0;
        end
        full = 8'((64'd1 << n) - 64'd1);
        an   = dark ? full : (full & ~8'(64'd1 << addr));
        fd   = (kk % (SLOT * n)) == (SLOT * n - 1);
        return {fd, an, seg};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        logic [16:0] e8, e5;
        e8 = model_out(8, k, act8);
        e5 = model_out(5, k, act5);
        @(posedge clk);
        if ((k % (SLOT * 8)) == SLOT * 8 - 1) act8 = load ? data : stg8;
        if (load) stg8 = data;
        if ((k % (SLOT * 5)) == SLOT * 5 - 1) act5 = load ? (data & 64'hFF_FFFF_FFFF) : stg5;
        if (load) stg5 = data & 64'hFF_FFFF_FFFF;
        k++;
        @(negedge clk);
        check("seg8", 64'(bus8.disp_seg_o), 64'(e8[7:0]));
        check("an8",  64'(bus8.disp_an_o),  64'(e8[15:8]));
        check("fd8",  64'(bus8.frame_done), 64'(e8[16]));
        check("seg5", 64'(bus5.disp_seg_o), 64'(e5[7:0]));
        check("an5",  64'(bus5.disp_an_o),  64'(e5[12:8]));
        check("fd5",  64'(bus5.frame_done), 64'(e5[16]));
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step();
    endtask

    task automatic run_to(input int unsigned phase);
        for (int unsigned i = 0; i < SLOT * 8 && (k % (SLOT * 8)) != phase; i++) step();
    endtask

    task automatic pulse_load(input logic [63:0] d);
        data = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_seg8"}, 64'(bus8.disp_seg_o), 64'hFF);
        check({tag, "_an8"},  64'(bus8.disp_an_o),  64'hFF);
        check({tag, "_fd8"},  64'(bus8.frame_done), 64'h0);
        check({tag, "_seg5"}, 64'(bus5.disp_seg_o), 64'hFF);
        check({tag, "_an5"},  64'(bus5.disp_an_o),  64'h1F);
        check({tag, "_fd5"},  64'(bus5.frame_done), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        k = 0; act8 = '0; stg8 = '0; act5 = '0; stg5 = '0;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] d;
        compared = 0; mismatched = 0;
        rst = 1'b1; data = '0; load = 1'b0; mode = 1'b0;
        dp_v = '0; blank_v = '0; blink_v = '0; lzs = 1'b0; bright = 4'd15;
        k = 0; act8 = '0; stg8 = '0; act5 = '0; stg5 = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Hex scan of 0x87654321 at full brightness, then decimal points.
        pulse_load(64'h0000_0000_8765_4321);
        run(300);
        dp_v = 8'b1000_0101;
        run(130);
        dp_v = '0;

        // Tear-free update: load mid-frame, then load exactly on the wrap tick.
        run_to(60);
        pulse_load({$urandom(), $urandom()});
        run(200);
        run_to(SLOT * 8 - 1);
        pulse_load({$urandom(), $urandom()});
        run(150);

        // Leading-zero suppression, then an all-zero value.
        lzs = 1'b1;
        pulse_load(64'h0000_0000_0000_0A05);
        run(300);
        pulse_load(64'h0);
        run(300);
        lzs = 1'b0;

        // Raw bytes with blank and blink masks across several blink phases.
        mode = 1'b1;
        d = {$urandom(), $urandom()};
        d[31:24] = 8'h7F;
        blank_v = 8'h20;
        blink_v = 8'h04;
        pulse_load(d);
        run(SLOT * 8 * 6);
        blank_v = '0;
        blink_v = '0;

        // Reduced brightness.
        mode = 1'b0;
        pulse_load({$urandom(), $urandom()});
        bright = 4'd3;
        run(260);
        bright = 4'd0;
        run(260);
        bright = 4'd15;

        // Randomised mix of modes, masks and loads.
        repeat (30) begin
            mode    = 1'($urandom_range(0, 1));
            lzs     = 1'($urandom_range(0, 1));
            dp_v    = 8'($urandom());
            blank_v = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
            blink_v = 8'($urandom());
            bright  = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                pulse_load(64'($urandom_range(0, 65535)));
            else if ($urandom_range(0, 1) == 0)
                pulse_load({$urandom(), $urandom()});
            run($urandom_range(3, 90));
        end

        // Mid-frame reset with pending staging data.
        mode = 1'b0; lzs = 1'b0; dp_v = '0; blank_v = '0; blink_v = '0; bright = 4'd15;
        run_to(70);
        pulse_load({$urandom(), $urandom()});
        run(5);
        do_reset();
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
